// File: rtl/des_key_schedule_pkg.sv
// Purpose : DES key-schedule constants and helpers shared by the key schedule
//           top and its PC-2 selection sub-module.
// Contents: FSM state codes, PC-1/PC-2 permutation tables, per-round shift
//           amounts, and 28-bit circular rotate helpers.
package des_key_schedule_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // PC-1: entry j (0-based) gives the DES key bit number (1 = MSB) that
  // lands in C/D bit j+1. Entries 0..27 build C, 28..55 build D.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry j (0-based) gives the CD bit number (1 = C MSB) that lands
  // in subkey bit j+1.
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-shift amount for DES rounds 1..16, stored at index 0..15.
  localparam logic [1:0] SH [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // 28-bit circular rotate left by 1 or 2 (the only amounts DES uses).
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotl28 = {x[26:0], x[27]};
      2'd2:    rotl28 = {x[25:0], x[27:26]};
      default: rotl28 = x;
    endcase
  endfunction

  // 28-bit circular rotate right by 1 or 2; undoes rotl28 for decryption.
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotr28 = {x[0], x[27:1]};
      2'd2:    rotr28 = {x[1:0], x[27:2]};
      default: rotr28 = x;
    endcase
  endfunction

endpackage

// File: rtl/des_key_schedule_pc2.sv
// Purpose : Combinational PC-2 selection, 56-bit C/D -> 48-bit subkey.
// Ports   : c, d (28 b each, bit 27 = DES bit 1 of the half) in;
//           k_sub (48 b, bit 47 = subkey bit 1) out.
module des_key_schedule_pc2
  import des_key_schedule_pkg::*;
(
  input  logic [27:0] c,
  input  logic [27:0] d,
  output logic [47:0] k_sub
);

  logic [55:0] cd;
  assign cd = {c, d};

  // DES bit p (1-based, MSB first) of a 56-bit vector lives at index 56-p.
  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign k_sub[47-j] = cd[56-PC2[j]];
  end

  // PC-2 drops CD bits 9, 18, 22, 25, 35, 38, 43 and 54.
  logic unused_dropped;
  assign unused_dropped = ^{cd[47], cd[38], cd[34], cd[31],
                            cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// Purpose : Iterative DES key schedule; streams 16 PC-2 subkeys per start,
//           K1..K16 for encrypt or K16..K1 for decrypt, over valid/ready.
// Ports   : clk, rst_n (async, active-low), start, decrypt, key[63:0] in;
//           k_ready in; k_sub[47:0], k_valid, round_idx[3:0], busy, done out.
module des_key_schedule
  import des_key_schedule_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic        k_ready,
  output logic [47:0] k_sub,
  output logic        k_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  logic [1:0]  state;
  logic [27:0] c_reg;
  logic [27:0] d_reg;
  logic        dir;     // latched decrypt flag for the running sequence
  logic [3:0]  idx;

  // ---------------------------------------------------------------------
  // PC-1 of the incoming key. key[63] is DES bit 1, so DES bit p -> key[64-p].
  // ---------------------------------------------------------------------
  logic [55:0] key_pc1;
  for (genvar j = 0; j < 56; j++) begin : g_pc1
    assign key_pc1[55-j] = key[64-PC1[j]];
  end

  // Parity bits (DES bits 8, 16, .. 64) take no part in the schedule.
  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8],  key[0]};

  // Encrypt starts at C1/D1 (one left shift of C0/D0). Decrypt starts at
  // C16/D16, which equals C0/D0 because the shifts sum to a full 28 turn.
  logic [27:0] c_load;
  logic [27:0] d_load;
  assign c_load = decrypt ? key_pc1[55:28] : rotl28(key_pc1[55:28], 2'd1);
  assign d_load = decrypt ? key_pc1[27:0]  : rotl28(key_pc1[27:0],  2'd1);

  // ---------------------------------------------------------------------
  // Next C/D on acceptance. While emitting position idx the registers hold
  // C(idx+1) for encrypt and C(16-idx) for decrypt; stepping to the next
  // position needs SH of round idx+2 (left) or of round 16-idx (right).
  // Package SH is 0-based, hence idx+1 and 15-idx. At idx=15 the encrypt
  // index wraps but the value is never used, as the sequence ends there.
  // ---------------------------------------------------------------------
  logic [1:0]  shift_n;
  logic [27:0] c_next;
  logic [27:0] d_next;
  assign shift_n = dir ? SH[4'd15 - idx] : SH[idx + 4'd1];
  assign c_next  = dir ? rotr28(c_reg, shift_n) : rotl28(c_reg, shift_n);
  assign d_next  = dir ? rotr28(d_reg, shift_n) : rotl28(d_reg, shift_n);

  logic accept;
  assign accept = (state == ST_RUN) && k_ready;

  // ---------------------------------------------------------------------
  // FSM, round counter and C/D registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      c_reg <= '0;
      d_reg <= '0;
      dir   <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            c_reg <= c_load;
            d_reg <= d_load;
            dir   <= decrypt;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (idx == 4'd15) begin
              state <= ST_FIN;
            end else begin
              idx   <= idx + 4'd1;
              c_reg <= c_next;
              d_reg <= d_next;
            end
          end
        end
        ST_FIN: begin
          idx   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. The subkey is a pure function of the C/D registers, so it is
  // naturally stable while the consumer stalls.
  // ---------------------------------------------------------------------
  des_key_schedule_pc2 u_pc2 (
    .c     (c_reg),
    .d     (d_reg),
    .k_sub (k_sub)
  );

  assign k_valid   = (state == ST_RUN);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_FIN);
  assign round_idx = idx;

endmodule

// File: tb/tb_des_key_schedule.sv
// Purpose : Self-checking bench for des_key_schedule; compares every emitted
//           subkey against a table-driven DES key-schedule model.
// Ports   : none (top-level bench).
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        k_ready;
  logic [47:0] k_sub;
  logic        k_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  string cur_test = "init";

  des_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .decrypt   (decrypt),
    .key       (key),
    .k_ready   (k_ready),
    .k_sub     (k_sub),
    .k_valid   (k_valid),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference tables written straight from the DES standard.
  int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                     10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                     23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48,
                     44,49,39,56,34,53, 46,42,50,36,29,32};
  int SH_T  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] exp_enc [16];   // model K1..K16
  logic [47:0] first_k;
  logic [47:0] last_k;

  // Model: Kr bit p of CD = CD0 bit ((p + total shift) mod 28) per half,
  // computed from cumulative shift counts rather than stepwise rotation.
  task automatic build_model(input logic [63:0] k);
    logic kb [1:64];
    logic c0 [28];
    logic d0 [28];
    logic [63:0] t;
    logic [47:0] ks;
    int s;
    int p;
    t = k;
    for (int i = 1; i <= 64; i++) begin
      kb[i] = t[63];
      t = t << 1;
    end
    for (int i = 0; i < 28; i++) begin
      c0[i] = kb[PC1_T[i]];
      d0[i] = kb[PC1_T[i+28]];
    end
    s = 0;
    for (int r = 0; r < 16; r++) begin
      s += SH_T[r];
      ks = '0;
      for (int j = 0; j < 48; j++) begin
        p = PC2_T[j] - 1;
        ks = {ks[46:0], (p < 28) ? c0[(p + s) % 28] : d0[(p - 28 + s) % 28]};
      end
      exp_enc[r] = ks;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full 16-subkey sequence from IDLE and checks every handshake.
  task automatic run_seq(input logic [63:0] k, input logic dec, input bit rnd_ready,
                         input bit disturb, input bit chk_cycle);
    int n;
    int cyc;
    bit got_done;
    bit prev_stall;
    logic [47:0] prev_k;
    logic [3:0]  prev_idx;
    build_model(k);
    key = k;
    decrypt = dec;
    start = 1'b1;
    k_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("first_valid", {63'd0, k_valid}, 64'd1);
    chk("busy_run", {63'd0, busy}, 64'd1);
    n = 0;
    got_done = 0;
    prev_stall = 0;
    prev_k = '0;
    prev_idx = '0;
    while (!got_done && cyc < 400) begin
      if (done) begin
        got_done = 1;
        chk("handshakes", n, 16);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        if (chk_cycle) chk("done_cycle", cyc, 17);
      end else if (k_valid) begin
        if (prev_stall) begin
          chk("stall_k_sub", k_sub, prev_k);
          chk("stall_idx", round_idx, prev_idx);
        end
        k_ready = rnd_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
        if (k_ready) begin
          if (n < 16) begin
            chk("k_sub", k_sub, dec ? exp_enc[15-n] : exp_enc[n]);
            chk("round_idx", round_idx, n);
            if (n == 0) first_k = k_sub;
            if (n == 15) last_k = k_sub;
          end else begin
            chk("extra_handshake", n, 15);
          end
          n++;
        end
        prev_stall = !k_ready;
        prev_k = k_sub;
        prev_idx = round_idx;
      end
      if (disturb && n < 15) begin
        start = 1'($urandom_range(0, 1));
        key = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      if (!got_done) begin
        tick();
        cyc++;
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    start = 1'b0;
    k_ready = 1'b0;
    tick();
    chk("done_pulse_end", {63'd0, done}, 64'd0);
    chk("idle_valid", {63'd0, k_valid}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  localparam logic [63:0] SPEC_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] SPEC_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] SPEC_K16 = 48'hCB3D8B0E17F5;

  initial begin
    int cyc;
    // T1: reset held with start asserted
    cur_test = "T1";
    rst_n = 1'b0;
    start = 1'b1;
    decrypt = 1'b0;
    key = SPEC_KEY;
    k_ready = 1'b1;
    #2;
    chk("rst_k_valid", {63'd0, k_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_k_sub", k_sub, 64'd0);
    chk("rst_round_idx", round_idx, 64'd0);
    tick();
    tick();
    chk("rst_hold_valid", {63'd0, k_valid}, 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {63'd0, k_valid}, 64'd0);

    // T2: encrypt with the worked-example key
    cur_test = "T2";
    run_seq(SPEC_KEY, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("enc_first", first_k, SPEC_K1);
    chk("enc_last", last_k, SPEC_K16);

    // T3: decrypt, same key
    cur_test = "T3";
    run_seq(SPEC_KEY, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("dec_first", first_k, SPEC_K16);
    chk("dec_last", last_k, SPEC_K1);

    // T4: random backpressure, both directions
    cur_test = "T4";
    run_seq(SPEC_KEY, 1'b0, 1'b1, 1'b0, 1'b0);
    run_seq(SPEC_KEY, 1'b1, 1'b1, 1'b0, 1'b0);

    // T5: start/key/decrypt churn during RUN, then back-to-back restarts
    cur_test = "T5";
    run_seq(SPEC_KEY, 1'b0, 1'b1, 1'b1, 1'b0);
    run_seq({$urandom, $urandom}, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_seq({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    end

    // T6: asynchronous reset at round_idx 7
    cur_test = "T6";
    key = {$urandom, $urandom};
    decrypt = 1'b0;
    start = 1'b1;
    k_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (round_idx != 4'd7 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("reach_idx7", round_idx, 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_k_valid", {63'd0, k_valid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_k_sub", k_sub, 64'd0);
    chk("arst_round_idx", round_idx, 64'd0);
    tick();
    chk("arst_no_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("arst_no_done2", {63'd0, done}, 64'd0);
    chk("arst_idle", {63'd0, k_valid}, 64'd0);
    cur_test = "T6b";
    run_seq(SPEC_KEY, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_k1", first_k, SPEC_K1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
